// File: rtl/accum_delta_decoder_if.sv
// accum_delta_decoder_if: sample-in / delta-out valid-ready bus of the delta decoder
interface accum_delta_decoder_if #(parameter int WIDTH = 4);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_SUM;
  logic             IN_SYNC;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_D;
  logic             OUT_WRAP;
  modport slave (input IN_VALID, IN_SUM, IN_SYNC, OUT_READY,
                 output IN_READY, OUT_VALID, OUT_D, OUT_WRAP);
  modport master (output IN_VALID, IN_SUM, IN_SYNC, OUT_READY,
                  input IN_READY, OUT_VALID, OUT_D, OUT_WRAP);
endinterface

// File: rtl/accum_delta_decoder.sv
// accum_delta_decoder: recovers increments from a running-sum stream via a 2-entry output buffer
module accum_delta_decoder #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                C,
  input  logic                CLR,
  accum_delta_decoder_if.slave bus,
  output logic [CNTW-1:0]     COUNT
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH:0]   e0_q, e0_d, e1_q, e1_d, ent;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             rdy_q, acc, pop, wpos;
  always_comb begin
    acc     = bus.IN_VALID & rdy_q;
    pop     = (cnt_q != 2'd0) & bus.OUT_READY;
    wpos    = (cnt_q == 2'd1) & !pop;
    ent     = {(state_q == RUN) & !bus.IN_SYNC & (bus.IN_SUM < prev_q),
               bus.IN_SUM - (bus.IN_SYNC ? '0 : prev_q)};
    e0_d    = (acc & !wpos) ? ent : pop ? e1_q : e0_q;
    e1_d    = (acc & wpos) ? ent : e1_q;
    cnt_d   = cnt_q + {1'b0, acc} - {1'b0, pop};
    prev_d  = acc ? bus.IN_SUM : prev_q;
    state_d = acc ? RUN : state_q;
    count_d = !acc ? count_q : bus.IN_SYNC ? CNTW'(1) : (&count_q) ? count_q : count_q + 1'b1;
  end
  // ready is registered from the next occupancy so OUT_READY never reaches IN_READY combinationally
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      prev_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      rdy_q   <= cnt_d < 2'd2;
    end
  end
  assign bus.IN_READY  = rdy_q;
  assign bus.OUT_VALID = cnt_q != 2'd0;
  assign bus.OUT_D     = e0_q[WIDTH-1:0];
  assign bus.OUT_WRAP  = e0_q[WIDTH];
  assign COUNT         = count_q;
endmodule

// File: tb/tb_accum_delta_decoder.sv
// tb_accum_delta_decoder: scoreboard bench for the delta decoder, with a CNTW=2 twin for saturation
module tb_accum_delta_decoder;
  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] count;
  logic [1:0] count2;
  accum_delta_decoder_if #(.WIDTH(4)) bus ();
  accum_delta_decoder_if #(.WIDTH(4)) bus2 ();
  assign bus2.IN_VALID  = bus.IN_VALID;
  assign bus2.IN_SUM    = bus.IN_SUM;
  assign bus2.IN_SYNC   = bus.IN_SYNC;
  assign bus2.OUT_READY = bus.OUT_READY;
  accum_delta_decoder #(.WIDTH(4), .CNTW(8)) dut (.C(C), .CLR(CLR), .bus(bus), .COUNT(count));
  accum_delta_decoder #(.WIDTH(4), .CNTW(2)) dut2 (.C(C), .CLR(CLR), .bus(bus2), .COUNT(count2));
  always #5 C = ~C;
  typedef struct {logic [3:0] d; logic w;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errs = 0, checks = 0;
  logic [3:0] prev_m = '0;
  logic run_m = 1'b0;
  int cnt_m = 0, cnt2_m = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] s, input logic sy);
    bit ok = 0;
    exp_t e;
    bus.IN_VALID = 1'b1;
    bus.IN_SUM   = s;
    bus.IN_SYNC  = sy;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.IN_READY) begin
        @(posedge C);
        ok = 1;
      end else @(negedge C);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      return;
    end
    e.d = s - (sy ? 4'd0 : prev_m);
    e.w = run_m & !sy & (s < prev_m);
    q.push_back(e);
    prev_m = s;
    run_m  = 1'b1;
    cnt_m  = sy ? 1 : (cnt_m < 255 ? cnt_m + 1 : 255);
    cnt2_m = sy ? 1 : (cnt2_m < 3 ? cnt2_m + 1 : 3);
    @(negedge C);
    check("count", count, cnt_m);
    check("count2", count2, cnt2_m);
  endtask
  task automatic drain();
    bus.IN_VALID = 1'b0;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge C);
    @(negedge C);
    check("drain_left", q.size(), 0);
  endtask
  // results are judged between edges, after the bench has settled its inputs
  always @(negedge C) begin
    #3;
    if (!CLR && bus.OUT_VALID) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else if (bus.OUT_READY) begin
        mon_e = q.pop_front();
        check("out_d", bus.OUT_D, mon_e.d);
        check("out_wrap", bus.OUT_WRAP, mon_e.w);
      end else begin
        check("hold_d", bus.OUT_D, q[0].d);
        check("hold_wrap", bus.OUT_WRAP, q[0].w);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.IN_VALID = 1'b0;
    bus.IN_SUM = '0;
    bus.IN_SYNC = 1'b0;
    bus.OUT_READY = 1'b1;
    #2;
    check("rst_ready", bus.IN_READY, 0);
    check("rst_valid", bus.OUT_VALID, 0);
    check("rst_d", bus.OUT_D, 0);
    check("rst_wrap", bus.OUT_WRAP, 0);
    check("rst_count", count, 0);
    @(negedge C);
    CLR = 1'b0;
    #2;
    check("ready_pre_edge", bus.IN_READY, 0);
    @(negedge C);
    check("ready_post_edge", bus.IN_READY, 1);
    send(4'd3, 0);
    send(4'd5, 0);
    send(4'd12, 0);
    send(4'd14, 0);
    send(4'd2, 0);
    send(4'd2, 0);
    send(4'd9, 0);
    send(4'd6, 1);
    send(4'd7, 0);
    drain();
    bus.OUT_READY = 1'b0;
    send(4'd1, 1);
    send(4'd4, 0);
    check("ready_full", bus.IN_READY, 0);
    fork
      send(4'd8, 0);
      begin
        repeat (3) @(negedge C);
        bus.OUT_READY = 1'b1;
      end
    join
    drain();
    bus.OUT_READY = 1'b0;
    send(4'd3, 1);
    send(4'd9, 0);
    bus.IN_VALID = 1'b0;
    #1 CLR = 1'b1;
    #1;
    check("clr_valid", bus.OUT_VALID, 0);
    check("clr_count", count, 0);
    check("clr_count2", count2, 0);
    check("clr_ready", bus.IN_READY, 0);
    q.delete();
    prev_m = '0;
    run_m = 1'b0;
    cnt_m = 0;
    cnt2_m = 0;
    @(negedge C);
    CLR = 1'b0;
    bus.OUT_READY = 1'b1;
    @(negedge C);
    send(4'd5, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
